ex_muldiv: RTL
==============

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width; legal values are even and at least 8.
REQ-002 SHALL have parameter REGW, default 5, meaning the destination register address width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port md_req_i  in  1  request strobe from the ID/EX stage, sampled only when md_ready_o=1.
REQ-006 SHALL have port md_op_i  in  3  operation, RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port md_op_a_i  in  XLEN  rs1 operand (multiplicand or dividend).
REQ-008 SHALL have port md_op_b_i  in  XLEN  rs2 operand (multiplier or divisor).
REQ-009 SHALL have port md_reg_waddr_i  in  REGW  destination register tag.
REQ-010 SHALL have port md_kill_i  in  1  flush from the flow controller; aborts the operation in progress.
REQ-011 SHALL have port md_ready_o  out  1  high when idle and able to accept a request.
REQ-012 SHALL have port md_busy_o  out  1  high while an operation is in flight; the flow controller uses it as an EX stall.
REQ-013 SHALL have port md_valid_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have port md_result_o  out  XLEN  registered result.
REQ-015 SHALL have port md_reg_waddr_o  out  REGW  tag of the completed operation.

Function
REQ-016 SHALL implement an FSM with states IDLE, CALC and DONE.
- md_ready_o = (state==IDLE).
- md_busy_o = (state!=IDLE).
REQ-017 SHALL accept a request only in IDLE with md_req_i=1 and md_kill_i=0.
- Operands, op and tag latched at acceptance.
- md_req_i in CALC or DONE ignored.
REQ-018 SHALL, for a normal operation accepted at edge T:
- CALC for XLEN cycles, one bit per cycle (shift-add multiply, restoring divide).
- XLEN-bit iteration counter of width clog2(XLEN+1).
- Enter DONE with md_valid_o=1 in cycle T+XLEN+1.
- Return to IDLE next cycle.
REQ-019 SHALL handle the special cases in one step, IDLE->DONE with md_valid_o=1 in cycle T+1:
- Divisor zero: DIV/DIVU quotient all ones; REM/REMU = dividend.
- Signed overflow, DIV/REM of -2^(XLEN-1) by -1: quotient = dividend, remainder = 0.
REQ-020 SHALL compute on magnitudes and sign-correct the result when entering DONE:
- MUL: low XLEN bits of the 2*XLEN product.
- MULH: high half, signed x signed.
- MULHSU: high half, signed a x unsigned b.
- MULHU: high half, unsigned x unsigned.
- Quotient negative iff sign(a) xor sign(b) for signed DIV.
- Remainder takes the sign of the dividend for signed REM.
REQ-021 SHALL update md_result_o and md_reg_waddr_o only on entry to DONE and hold them until the next completion.
REQ-022 SHALL, on md_kill_i=1 in any state:
- Go to IDLE at the next edge.
- Produce no md_valid_o, including when killed in DONE.
- Suppress a same-cycle request.
REQ-023 SHALL hold md_valid_o for exactly one cycle per completed operation and never assert it twice for one request.

Reset
REQ-024 SHALL, while rst=1, immediately force:
- state IDLE;
- md_busy_o=0, md_valid_o=0, md_ready_o=1;
- md_result_o=0, md_reg_waddr_o=0, counter=0.
REQ-025 SHALL abandon an in-flight operation on reset with no later completion; the first edge after deassertion may accept a request.

Verification (XLEN=32, acceptance at edge T)
REQ-026 SHALL cover MUL 7 x 0xFFFFFFFD -> md_valid_o in T+33, result 0xFFFFFFEB, tag echoed.
REQ-027 SHALL cover multiply high halves:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-028 SHALL cover signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; both valid in T+33.
REQ-029 SHALL cover the special cases, each valid in T+1:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM same operands -> 0.
REQ-030 SHALL cover kill: md_kill_i=1 in cycle T+10 -> md_busy_o=0 in T+11, no md_valid_o ever; a new MUL at T+11 completes correctly in T+44.
REQ-031 SHALL cover async reset and busy requests:
- rst pulsed mid-CALC -> all outputs at reset values before the next clock edge, no completion afterwards.
- md_req_i held high during CALC -> exactly one completion.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle
// shift-add multiply and restoring divide on magnitudes, with sign fix-up on completion.
module ex_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_req_i,
    input  logic [2:0]      md_op_i,
    input  logic [XLEN-1:0] md_op_a_i,
    input  logic [XLEN-1:0] md_op_b_i,
    input  logic [REGW-1:0] md_reg_waddr_i,
    input  logic            md_kill_i,
    output logic            md_ready_o,
    output logic            md_busy_o,
    output logic            md_valid_o,
    output logic [XLEN-1:0] md_result_o,
    output logic [REGW-1:0] md_reg_waddr_o
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] acc_q, lo_q, opb_q, result_q;
    logic [REGW-1:0] tag_q, waddr_q;
    logic            valid_q;

    logic            a_sgn, b_sgn, neg_in, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] acc_d, lo_d, quo, rem, fin;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        a_sgn    = md_op_a_i[XLEN-1] & (md_op_i == 3'd1 || md_op_i == 3'd2 ||
                                         md_op_i == 3'd4 || md_op_i == 3'd6);
        b_sgn    = md_op_b_i[XLEN-1] & (md_op_i == 3'd1 || md_op_i == 3'd4 || md_op_i == 3'd6);
        a_mag    = a_sgn ? -md_op_a_i : md_op_a_i;
        b_mag    = b_sgn ? -md_op_b_i : md_op_b_i;
        // Remainder and MULHSU follow the dividend/multiplicand sign only.
        neg_in   = (md_op_i == 3'd2 || md_op_i == 3'd6) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = md_op_i[2] && (md_op_b_i == '0);
        div_ovf  = md_op_i[2] && !md_op_i[0] && (md_op_a_i == MINV) && (md_op_b_i == '1);
        if (div_zero) spec_res = md_op_i[1] ? md_op_a_i : '1;
        else          spec_res = md_op_i[1] ? '0 : md_op_a_i;
    end

    always_comb begin
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        shifted = {acc_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opb_q};
        if (op_q[2]) begin
            acc_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~diff[XLEN]};
        end else begin
            acc_d = sum[XLEN:1];
            lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end
        prod = {acc_d, lo_d};
        if (neg_q) prod = -prod;
        quo = neg_q ? -lo_d : lo_d;
        rem = neg_q ? -acc_d : acc_d;
        case (op_q)
            3'd0:       fin = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fin = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: fin = quo;
            default:    fin = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (md_kill_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (md_req_i) begin
                        op_q  <= md_op_i;
                        tag_q <= md_reg_waddr_i;
                        if (div_zero || div_ovf) begin
                            result_q <= spec_res;
                            waddr_q  <= md_reg_waddr_i;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            acc_q   <= '0;
                            lo_q    <= a_mag;
                            opb_q   <= b_mag;
                            neg_q   <= neg_in;
                            cnt_q   <= CW'(XLEN);
                            state_q <= CALC;
                        end
                    end
                    CALC: begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            result_q <= fin;
                            waddr_q  <= tag_q;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign md_ready_o     = (state_q == IDLE);
    assign md_busy_o      = (state_q != IDLE);
    // A kill arriving during the DONE cycle swallows the completion pulse.
    assign md_valid_o     = valid_q & ~md_kill_i;
    assign md_result_o    = result_q;
    assign md_reg_waddr_o = waddr_q;
endmodule
